// File: rtl/xtor_pkg.sv
// Shared types and defaults for the request-queue transactor.
package xtor_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        WAIT_RDY = 1'b0,
        RUN      = 1'b1
    } state_t;

endpackage

// File: rtl/xtor_sync_fifo.sv
// Synchronous FIFO storage with wrapping pointers and an occupancy count.
module xtor_sync_fifo
    import xtor_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = DEF_DW
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DW-1:0]            push_data,
    output logic [DW-1:0]            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
    localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Storage is deliberately left unreset; only the pointers matter.
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= push_data;
    end

    assign head  = mem[rptr];
    assign full  = (level == LVL_MAX);
    assign empty = (level == '0);

endmodule

// File: rtl/xtor_req_queue.sv
// Request queue feeding a downstream core through a ready-gated FSM.
module xtor_req_queue
    import xtor_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = DEF_DW
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [DW-1:0]          push_data,
    input  logic                   flush,
    input  logic                   core_ready,
    output logic                   core_valid,
    output logic [DW-1:0]          core_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            issued_count
);

    state_t        state;
    state_t        state_nxt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [DW-1:0] head;

    assign push = push_valid && push_ready && !flush;
    assign pop  = core_valid && core_ready;

    xtor_sync_fifo #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .push_data(push_data),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= WAIT_RDY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_RDY: if (core_ready)  state_nxt = RUN;
            RUN:      if (!core_ready) state_nxt = WAIT_RDY;
            default:  state_nxt = WAIT_RDY;
        endcase
    end

    always_comb begin
        core_valid = 1'b0;
        unique case (state)
            WAIT_RDY: core_valid = 1'b0;
            RUN:      core_valid = !empty;
            default:  core_valid = 1'b0;
        endcase
    end

    assign push_ready = !full;
    // Mask the unreset storage so the core never sees stale data in reset.
    assign core_data  = reset ? '0 : head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)    issued_count <= '0;
        else if (pop) issued_count <= issued_count + 16'd1;
    end

endmodule

// File: tb/tb_xtor_req_queue.sv
// Directed plus random checking of xtor_req_queue against a queue model.
module tb_xtor_req_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          flush;
    logic          core_ready;
    logic          core_valid;
    logic [DW-1:0] core_data;
    logic [2:0]    level;
    logic [15:0]   issued_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] q[$];
    bit            rdy_q;
    logic [15:0]   m_cnt;

    always #5 clock = ~clock;

    xtor_req_queue #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_data   (push_data),
        .flush       (flush),
        .core_ready  (core_ready),
        .core_valid  (core_valid),
        .core_data   (core_data),
        .level       (level),
        .issued_count(issued_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Core sees a word only if it was ready at the last edge and data exists.
    task automatic cyc(input logic pv, input logic [DW-1:0] pd,
                       input logic fl, input logic cr);
        bit ev;
        bit do_pop;
        bit do_push;
        @(negedge clock);
        ev = rdy_q && (q.size() != 0);
        check("core_valid", 32'(core_valid), 32'(ev));
        if (ev) check("core_data", core_data, q[0]);
        check("push_ready", 32'(push_ready), 32'(q.size() != DEPTH));
        check("level", 32'(level), 32'(q.size()));
        check("issued_count", 32'(issued_count), 32'(m_cnt));
        push_valid = pv;
        push_data  = pd;
        flush      = fl;
        core_ready = cr;
        do_pop  = ev && cr;
        do_push = pv && (q.size() != DEPTH) && !fl;
        @(posedge clock);
        if (do_pop) begin
            void'(q.pop_front());
            m_cnt++;
        end
        if (fl) q.delete();
        else if (do_push) q.push_back(pd);
        rdy_q = cr;
    endtask

    task automatic model_reset();
        q.delete();
        rdy_q = 1'b0;
        m_cnt = '0;
    endtask

    initial begin
        reset      = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        flush      = 1'b0;
        core_ready = 1'b0;
        model_reset();
        #12;
        check("rst_core_valid", 32'(core_valid), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_issued", 32'(issued_count), 32'd0);
        check("rst_core_data", core_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // single word, held off until the core becomes ready
        cyc(1'b1, 32'h12345678, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("r033_level", 32'(level), 32'd1);
        check("r033_nvalid", 32'(core_valid), 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        #1 check("r033_valid", 32'(core_valid), 32'd1);
        check("r033_data", core_data, 32'h12345678);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        #1 check("r033_issued", 32'(issued_count), 32'd1);
        check("r033_empty", 32'(level), 32'd0);

        // back-to-back stream with the core ready
        cyc(1'b1, 32'h10, 1'b0, 1'b1);
        cyc(1'b1, 32'h20, 1'b0, 1'b1);
        cyc(1'b1, 32'h30, 1'b0, 1'b1);
        cyc(1'b1, 32'h40, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        #1 check("r034_issued", 32'(issued_count), 32'd5);

        // overfill while stalled
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(32'hA0 + i), 1'b0, 1'b0);
        #1 check("r035_level", 32'(level), 32'd4);
        check("r035_ready", 32'(push_ready), 32'd0);
        repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        #1 check("r035_issued", 32'(issued_count), 32'd9);

        // flush with a concurrent push
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'hB0 + i), 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        #1 check("r036_level", 32'(level), 32'd0);
        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        #1 check("r036_issued", 32'(issued_count), 32'd9);

        // ready drops mid-burst
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(32'hC0 + i), 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("r037_nvalid", 32'(core_valid), 32'd0);
        check("r037_level", 32'(level), 32'd2);
        repeat (4) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        #1 check("r037_issued", 32'(issued_count), 32'd13);

        // asynchronous reset in the middle of a stream
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'(32'hD0 + i), 1'b0, 1'b1);
        #1 check("r038_pre_valid", 32'(core_valid), 32'd1);
        #1 reset = 1'b1;
        #1 check("r038_valid", 32'(core_valid), 32'd0);
        check("r038_level", 32'(level), 32'd0);
        check("r038_issued", 32'(issued_count), 32'd0);
        check("r038_data", core_data, 32'd0);
        check("r038_ready", 32'(push_ready), 32'd1);
        model_reset();
        push_valid = 1'b0;
        flush      = 1'b0;
        core_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 500; i++) begin
            cyc(1'($urandom_range(0, 2) != 0), $urandom,
                1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 9) < 7));
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xtor_req_queue.md
XTOR_REQ_QUEUE -- requirements
Module: xtor_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of two, minimum 2.
REQ-002 Parameter DW, default 32, data word width.
REQ-003 Port clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port push_valid  input  1  producer offers push_data this cycle.
REQ-006 Port push_ready  output  1  queue can accept a word this cycle.
REQ-007 Port push_data  input  DW  word to enqueue.
REQ-008 Port flush  input  1  synchronous discard of all queued words.
REQ-009 Port core_ready  input  1  downstream core ready indication.
REQ-010 Port core_valid  output  1  drives the core's valid input.
REQ-011 Port core_data  output  DW  drives the core's data_i input.
REQ-012 Port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 Port issued_count  output  16  number of words delivered to the core since reset.

Function
REQ-014 Push accept SHALL occur on an edge where push_valid && push_ready && !flush.
REQ-015 push_ready SHALL equal (level != DEPTH) and SHALL NOT depend on same-cycle pops, so there is no write-through when full.
REQ-016 FSM states:
  - WAIT_RDY: core_valid=0.
  - RUN: core_valid=(level!=0).
REQ-017 WAIT_RDY->RUN SHALL occur on the first edge with core_ready=1.
REQ-018 RUN->WAIT_RDY SHALL occur on any edge with core_ready=0, with entries retained.
REQ-019 core_data SHALL equal the head entry whenever core_valid=1; it is don't-care otherwise.
REQ-020 A pop (deliver) SHALL occur on an edge where core_valid && core_ready; it removes the head and increments issued_count.
REQ-021 Delivery SHALL be one word per cycle at most; a stream of N queued words SHALL take N consecutive cycles while core_ready stays 1.
REQ-022 Simultaneous push and pop SHALL leave level unchanged, and data order SHALL be preserved.
REQ-023 A push into an empty queue SHALL appear on core_valid in the next cycle; there is no combinational bypass.
REQ-024 Pointers SHALL wrap modulo DEPTH; full versus empty SHALL be distinguished by level, or by an extra pointer bit.
REQ-025 flush=1 SHALL set level to 0 at the next edge; a same-cycle push SHALL be dropped and a same-cycle pop SHALL still count in issued_count.
REQ-026 issued_count SHALL wrap from 0xFFFF to 0x0000.
REQ-027 core_valid and push_ready SHALL be combinational from registers only, with no input-to-output path except via state.

Reset
REQ-028 While reset=1, all of the following SHALL hold:
  - state=WAIT_RDY, level=0, pointers=0, issued_count=0;
  - core_valid=0, push_ready=1.
REQ-029 core_data SHALL read 0 during reset; storage contents are otherwise not reset.
REQ-030 Reset asserted mid-stream SHALL discard all entries immediately, without waiting for a clock.

Structure
REQ-031 Shared package xtor_pkg SHALL hold the FSM state enum (WAIT_RDY, RUN) and the default DW/DEPTH constants.
REQ-032 Storage plus pointers SHALL be one sub-module, xtor_sync_fifo (push/pop/full/empty/level); the FSM and counter SHALL live in xtor_req_queue.

Verification
REQ-033 Reset with core_ready=0, then push 0x12345678 -> level=1, core_valid stays 0; raise core_ready -> next cycle core_valid=1, core_data=0x12345678; one edge later level=0, issued_count=1.
REQ-034 core_ready=1, push 0x10,0x20,0x30,0x40 back-to-back -> after the 4th push, push_ready=0 only if pushes outpace pops; core_data sequence 0x10,0x20,0x30,0x40 in consecutive cycles; issued_count=4.
REQ-035 core_ready=0, push 5 words with DEPTH=4 -> 5th word refused (push_ready=0), level=4; release -> exactly 4 words delivered in order.
REQ-036 Queue holding 3 words; flush together with push of 0xFFFFFFFF -> level=0 next cycle, core_valid=0, 0xFFFFFFFF never delivered.
REQ-037 core_ready drops after 2 of 4 words delivered -> core_valid=0 next cycle, level=2; core_ready returns -> remaining 2 delivered in order.
REQ-038 Assert reset asynchronously mid-stream (between edges) -> core_valid=0 and level=0 immediately; issued_count=0.
